// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Definitions shared by the Wishbone initiator and its helper blocks.
//   state_t     : controller FSM states (IDLE, BUS, RESP)
//   ADR_W_DEF   : default Wishbone address width
//   DAT_W_DEF   : default Wishbone data width
//   cmd_t/rsp_t : command {we, adr, wdata} and response {rdata, err} records
//   timer_width : bits needed to count 0..TIMEOUT, never less than one
// -----------------------------------------------------------------------------
package wb_pkg;

    localparam int ADR_W_DEF = 4;
    localparam int DAT_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic                 we;
        logic [ADR_W_DEF-1:0] adr;
        logic [DAT_W_DEF-1:0] wdata;
    } cmd_t;

    typedef struct packed {
        logic [DAT_W_DEF-1:0] rdata;
        logic                 err;
    } rsp_t;

    function automatic int timer_width(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : wb_pkg

// File: rtl/wishbone_master_ctrl_if.sv
// -----------------------------------------------------------------------------
// wishbone_master_ctrl_if
// Bundles the command port, the response port and the Wishbone bus of the
// initiator.
//   master modport : the controller's view (drives cmd_ready, rsp_*, wb_* out)
//   slave  modport : the environment's view (command source, response sink
//                    and Wishbone slave)
// -----------------------------------------------------------------------------
interface wishbone_master_ctrl_if #(
    parameter int ADR_W = 4,
    parameter int DAT_W = 32
) ();

    // command port
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_we;
    logic [ADR_W-1:0] cmd_adr;
    logic [DAT_W-1:0] cmd_wdata;

    // response port
    logic             rsp_valid;
    logic             rsp_ready;
    logic [DAT_W-1:0] rsp_rdata;
    logic             rsp_err;

    // Wishbone classic bus
    logic             wb_cyc;
    logic             wb_stb;
    logic             wb_we;
    logic [ADR_W-1:0] wb_adr;
    logic [DAT_W-1:0] wb_dat_mosi;
    logic [DAT_W-1:0] wb_dat_miso;
    logic             wb_ack;

    modport master (
        input  cmd_valid, cmd_we, cmd_adr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_mosi,
        input  wb_dat_miso, wb_ack
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_adr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_mosi,
        output wb_dat_miso, wb_ack
    );

endinterface : wishbone_master_ctrl_if

// File: rtl/wb_timeout_cnt.sv
// -----------------------------------------------------------------------------
// wb_timeout_cnt
// Saturating cycle counter that flags when a bus wait has run TIMEOUT cycles.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_clr      : restart the count from zero (wins over i_en)
//   i_en       : count this cycle
//   o_expired  : count has reached TIMEOUT-1; never set when TIMEOUT is 0
// -----------------------------------------------------------------------------
module wb_timeout_cnt
    import wb_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int                CNT_W   = timer_width(TIMEOUT);
    localparam logic [CNT_W-1:0]  EXP_VAL = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;

    // NOTE: state registers use non-blocking (<=) so every flop samples the
    // pre-edge values of its inputs, independent of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != '1)) begin
            // Saturate at all-ones so a long wait can never wrap back to zero.
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = (TIMEOUT != 0) && (r_cnt == EXP_VAL);

endmodule : wb_timeout_cnt

// File: rtl/wishbone_master_ctrl.sv
// -----------------------------------------------------------------------------
// wishbone_master_ctrl
// Single-transfer Wishbone classic initiator: one cyc/stb/ack cycle per
// accepted command, then one response (read data or timeout error).
//   clk, rst_n : clock, asynchronous active-low reset (aborts any transfer)
//   bus        : command / response / Wishbone signals (master modport)
//   busy       : high whenever the controller is not in IDLE
// All bus and response outputs are registered; cmd_ready and busy decode
// the state directly.
// -----------------------------------------------------------------------------
module wishbone_master_ctrl
    import wb_pkg::*;
#(
    parameter int ADR_W   = ADR_W_DEF,
    parameter int DAT_W   = DAT_W_DEF,
    parameter int TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    wishbone_master_ctrl_if.master bus,
    output logic                   busy
);

    state_t           r_state;
    state_t           w_state_nxt;

    logic             w_accept;
    logic             w_ack_end;
    logic             w_to_end;
    logic             w_rsp_take;
    logic             w_expired;

    logic             r_wb_cyc;
    logic             r_wb_stb;
    logic             r_wb_we;
    logic [ADR_W-1:0] r_wb_adr;
    logic [DAT_W-1:0] r_wb_dat_mosi;
    logic             r_rsp_valid;
    logic [DAT_W-1:0] r_rsp_rdata;
    logic             r_rsp_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_ack_end   = 1'b0;
        w_to_end    = 1'b0;
        w_rsp_take  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_BUS;
                end
            end
            ST_BUS: begin
                // An ack sampled on the expiry cycle still completes normally.
                if (bus.wb_ack) begin
                    w_ack_end   = 1'b1;
                    w_state_nxt = ST_RESP;
                end else if (w_expired) begin
                    w_to_end    = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    w_rsp_take  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    wb_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (w_accept),
        .i_en      (r_state == ST_BUS),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_cyc      <= 1'b0;
            r_wb_stb      <= 1'b0;
            r_wb_we       <= 1'b0;
            r_wb_adr      <= '0;
            r_wb_dat_mosi <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wb_cyc      <= 1'b1;
                r_wb_stb      <= 1'b1;
                r_wb_we       <= bus.cmd_we;
                r_wb_adr      <= bus.cmd_adr;
                r_wb_dat_mosi <= bus.cmd_wdata;
            end
            // Strobe drops on the terminating edge, so a slave that keeps
            // acking sees exactly one completed cycle. Address and write data
            // are left as they were.
            if (w_ack_end || w_to_end) begin
                r_wb_cyc    <= 1'b0;
                r_wb_stb    <= 1'b0;
                r_wb_we     <= 1'b0;
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= w_to_end;
                r_rsp_rdata <= (w_ack_end && !r_wb_we) ? bus.wb_dat_miso : '0;
            end
            if (w_rsp_take) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign bus.wb_cyc      = r_wb_cyc;
    assign bus.wb_stb      = r_wb_stb;
    assign bus.wb_we       = r_wb_we;
    assign bus.wb_adr      = r_wb_adr;
    assign bus.wb_dat_mosi = r_wb_dat_mosi;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_rdata   = r_rsp_rdata;
    assign bus.rsp_err     = r_rsp_err;
    assign bus.cmd_ready   = (r_state == ST_IDLE);
    assign busy            = (r_state != ST_IDLE);

endmodule : wishbone_master_ctrl

// File: tb/tb_wishbone_master_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wishbone_master_ctrl
// Bench for wishbone_master_ctrl: a register-block slave whose ack can be
// placed on any bus cycle (or withheld), a table of directed transfers,
// hand-written corner sequences, and random transfers predicted by a
// transfer-level model.
// -----------------------------------------------------------------------------
module tb_wishbone_master_ctrl;
    import wb_pkg::*;

    localparam int TIMEOUT = 15;

    typedef struct {
        cmd_t cmd;
        int   ack_at;   // bus cycle on which the slave acks; 0 = never
        int   hold;     // cycles rsp_ready is held low after rsp_valid
        rsp_t exp;
        int   exp_stb;  // cycles wb_stb is expected high
    } vec_t;

    logic clk;
    logic rst_n;
    logic busy;

    wishbone_master_ctrl_if #(.ADR_W(4), .DAT_W(32)) ifc ();

    wishbone_master_ctrl #(
        .ADR_W   (4),
        .DAT_W   (32),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc),
        .busy  (busy)
    );

    int total = 0;
    int bad   = 0;

    // slave state
    logic [31:0] slave_mem [16];
    int          ack_at    = 2;
    bit          stray_ack = 1'b0;
    int          bus_cyc_n = 0;
    int          stb_cnt   = 0;

    // reference model memory
    logic [31:0] model_mem [16];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    // Slave: updates on the falling edge so ack/data are stable at the DUT's
    // sampling edge. Ack is given on bus cycle ack_at, counted from 1.
    always @(negedge clk) begin
        if (ifc.wb_cyc && ifc.wb_stb) begin
            bus_cyc_n = bus_cyc_n + 1;
            stb_cnt   = stb_cnt + 1;
            if (ack_at != 0 && bus_cyc_n == ack_at) begin
                ifc.wb_ack = 1'b1;
                if (ifc.wb_we) begin
                    slave_mem[ifc.wb_adr] = ifc.wb_dat_mosi;
                    ifc.wb_dat_miso = $urandom;
                end else begin
                    ifc.wb_dat_miso = slave_mem[ifc.wb_adr];
                end
            end else begin
                ifc.wb_ack      = 1'b0;
                ifc.wb_dat_miso = $urandom;
            end
        end else begin
            bus_cyc_n       = 0;
            ifc.wb_ack      = stray_ack;
            ifc.wb_dat_miso = $urandom;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Waits (bounded) for rsp_valid, sampling on falling edges.
    task automatic wait_rsp(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (ifc.rsp_valid === 1'b1) break;
            @(negedge clk);
        end
        check({tag, "_rsp_valid"}, ifc.rsp_valid, 1);
    endtask

    task automatic take_rsp(input string tag);
        ifc.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ifc.rsp_ready = 1'b0;
        check({tag, "_rsp_dropped"}, ifc.rsp_valid, 0);
        check({tag, "_idle_ready"}, ifc.cmd_ready, 1);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int s0;
        s0 = stb_cnt;
        check({tag, "_cmd_ready"}, ifc.cmd_ready, 1);
        ifc.cmd_valid = 1'b1;
        ifc.cmd_we    = v.cmd.we;
        ifc.cmd_adr   = v.cmd.adr;
        ifc.cmd_wdata = v.cmd.wdata;
        ack_at        = v.ack_at;
        @(posedge clk);
        @(negedge clk);
        ifc.cmd_valid = 1'b0;
        check({tag, "_busy"}, busy, 1);
        wait_rsp(tag);
        check({tag, "_rdata"}, ifc.rsp_rdata, v.exp.rdata);
        check({tag, "_err"}, ifc.rsp_err, v.exp.err);
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, ifc.rsp_valid, 1);
            check({tag, "_hold_rdata"}, ifc.rsp_rdata, v.exp.rdata);
            check({tag, "_hold_err"}, ifc.rsp_err, v.exp.err);
            check({tag, "_hold_cmd_ready"}, ifc.cmd_ready, 0);
        end
        take_rsp(tag);
        check({tag, "_stb_cycles"}, 32'(stb_cnt - s0), 32'(v.exp_stb));
    endtask

    // Transfer-level prediction: an ack counts if it arrives no later than
    // the TIMEOUT-th bus cycle; otherwise the transfer ends in error after
    // TIMEOUT cycles.
    function automatic vec_t predict(input bit we, input logic [3:0] adr,
                                     input logic [31:0] data, input int k, input int hold);
        vec_t v;
        bit   ok;
        ok          = (k != 0) && (TIMEOUT == 0 || k <= TIMEOUT);
        v.cmd       = '{we, adr, data};
        v.ack_at    = k;
        v.hold      = hold;
        v.exp.err   = !ok;
        v.exp.rdata = (ok && !we) ? model_mem[adr] : 32'h0;
        v.exp_stb   = ok ? k : TIMEOUT;
        if (ok && we) model_mem[adr] = data;
        return v;
    endfunction

    vec_t vecs [8];

    initial begin
        vec_t rv;
        int   seen;

        for (int i = 0; i < 16; i++) slave_mem[i] = 32'h0;

        vecs[0] = '{'{1'b1, 4'd3,  32'hDEADBEEF}, 2,  0, '{32'h0,        1'b0}, 2};
        vecs[1] = '{'{1'b0, 4'd3,  32'h0},        2,  5, '{32'hDEADBEEF, 1'b0}, 2};
        vecs[2] = '{'{1'b0, 4'd7,  32'h0},        0,  0, '{32'h0,        1'b1}, 15};
        vecs[3] = '{'{1'b1, 4'd5,  32'h12345678}, 2,  0, '{32'h0,        1'b0}, 2};
        vecs[4] = '{'{1'b0, 4'd5,  32'h0},        15, 1, '{32'h12345678, 1'b0}, 15};
        vecs[5] = '{'{1'b0, 4'd5,  32'h0},        16, 0, '{32'h0,        1'b1}, 15};
        vecs[6] = '{'{1'b1, 4'd15, 32'hA5A50F0F}, 1,  0, '{32'h0,        1'b0}, 1};
        vecs[7] = '{'{1'b0, 4'd15, 32'h0},        3,  2, '{32'hA5A50F0F, 1'b0}, 3};

        // reset state
        rst_n         = 1'b0;
        ifc.cmd_valid = 1'b0;
        ifc.cmd_we    = 1'b0;
        ifc.cmd_adr   = '0;
        ifc.cmd_wdata = '0;
        ifc.rsp_ready = 1'b0;
        #23;
        check("rst_cyc", ifc.wb_cyc, 0);
        check("rst_stb", ifc.wb_stb, 0);
        check("rst_rsp_valid", ifc.rsp_valid, 0);
        check("rst_rsp_rdata", ifc.rsp_rdata, 0);
        check("rst_rsp_err", ifc.rsp_err, 0);
        check("rst_wb_adr", ifc.wb_adr, 0);
        check("rst_wb_mosi", ifc.wb_dat_mosi, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_cmd_ready", ifc.cmd_ready, 1);
        check("post_rst_busy", busy, 0);

        // directed table
        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // pending command during response stall is taken only in IDLE
        ifc.cmd_valid = 1'b1;
        ifc.cmd_we    = 1'b0;
        ifc.cmd_adr   = 4'd3;
        ack_at        = 2;
        @(posedge clk);
        @(negedge clk);
        ifc.cmd_we    = 1'b1;
        ifc.cmd_adr   = 4'd9;
        ifc.cmd_wdata = 32'hCAFEF00D;
        wait_rsp("pend_rd");
        check("pend_rd_rdata", ifc.rsp_rdata, 32'hDEADBEEF);
        for (int h = 0; h < 5; h++) begin
            @(negedge clk);
            check("pend_stall_stb", ifc.wb_stb, 0);
            check("pend_stall_ready", ifc.cmd_ready, 0);
        end
        take_rsp("pend_rd");
        check("pend_idle_stb", ifc.wb_stb, 0);
        @(posedge clk);
        @(negedge clk);
        ifc.cmd_valid = 1'b0;
        check("pend_wr_stb", ifc.wb_stb, 1);
        check("pend_wr_we", ifc.wb_we, 1);
        check("pend_wr_adr", ifc.wb_adr, 9);
        check("pend_wr_mosi", ifc.wb_dat_mosi, 32'hCAFEF00D);
        wait_rsp("pend_wr");
        check("pend_wr_err", ifc.rsp_err, 0);
        check("pend_wr_rdata", ifc.rsp_rdata, 0);
        take_rsp("pend_wr");

        // stray ack in IDLE
        @(posedge clk); #1 stray_ack = 1'b1;
        @(posedge clk); #1 stray_ack = 1'b0;
        @(negedge clk);
        check("stray_idle_busy", busy, 0);
        check("stray_idle_rsp", ifc.rsp_valid, 0);
        check("stray_idle_rdata", ifc.rsp_rdata, 0);

        // stray ack in RESP
        ifc.cmd_valid = 1'b1;
        ifc.cmd_we    = 1'b0;
        ifc.cmd_adr   = 4'd9;
        ack_at        = 2;
        @(posedge clk);
        @(negedge clk);
        ifc.cmd_valid = 1'b0;
        wait_rsp("stray_resp");
        @(posedge clk); #1 stray_ack = 1'b1;
        @(posedge clk); #1 stray_ack = 1'b0;
        @(negedge clk);
        check("stray_resp_valid", ifc.rsp_valid, 1);
        check("stray_resp_rdata", ifc.rsp_rdata, 32'hCAFEF00D);
        check("stray_resp_busy", busy, 1);
        check("stray_resp_stb", ifc.wb_stb, 0);
        take_rsp("stray_resp");
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ifc.rsp_valid === 1'b1) seen++;
        end
        check("stray_no_extra_rsp", 32'(seen), 0);

        // reset in the middle of a bus cycle
        ifc.cmd_valid = 1'b1;
        ifc.cmd_we    = 1'b0;
        ifc.cmd_adr   = 4'd1;
        ack_at        = 0;
        @(posedge clk);
        @(negedge clk);
        ifc.cmd_valid = 1'b0;
        @(negedge clk);
        check("mid_rst_pre_stb", ifc.wb_stb, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_cyc", ifc.wb_cyc, 0);
        check("mid_rst_stb", ifc.wb_stb, 0);
        check("mid_rst_rsp_valid", ifc.rsp_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_cmd_ready", ifc.cmd_ready, 1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ifc.rsp_valid === 1'b1 || ifc.wb_stb === 1'b1) seen++;
        end
        check("mid_rst_quiet", 32'(seen), 0);

        // random transfers against the model
        for (int i = 0; i < 16; i++) begin
            slave_mem[i] = 32'h0;
            model_mem[i] = 32'h0;
        end
        for (int n = 0; n < 40; n++) begin
            rv = predict(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
                         int'($urandom_range(0, 18)), int'($urandom_range(0, 3)));
            run_vec(rv, $sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_wishbone_master_ctrl
